// File: rtl/key_cond_pkg.sv
// Shared constants for the key conditioner: debounce defaults and FSM state encoding.
package key_cond_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_CNT_WIDTH       = 20;

  typedef logic [1:0] state_t;

  // Gray-ordered so each legal transition flips a single bit.
  localparam state_t IDLE_LOW  = 2'b00;
  localparam state_t WAIT_HIGH = 2'b01;
  localparam state_t IDLE_HIGH = 2'b11;
  localparam state_t WAIT_LOW  = 2'b10;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: non-blocking assignments keep s1 and q as two distinct flops; blocking would collapse the chain.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Debounces a raw key/switch into a registered level plus one-cycle rise and fall pulses.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Raw,
  output logic Level,
  output logic Rise,
  output logic Fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s2;
  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  sync2 u_sync2 (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (Raw),
    .q     (s2)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      Level <= 1'b0;
      Rise  <= 1'b0;
      Fall  <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle; only the accepting branch raises one for a single cycle.
      Rise <= 1'b0;
      Fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (s2) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s2) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HIGH;
            Level <= 1'b1;
            Rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!s2) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (s2) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LOW;
            Level <= 1'b0;
            Fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Randomized and directed bench for key_conditioner against a run-length debounce model.
module tb_key_conditioner;

  localparam int D = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Raw = 1'b0;
  logic Level, Rise, Fall;

  int n_cmp = 0;
  int n_bad = 0;

  key_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(3)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Raw   (Raw),
    .Level (Level),
    .Rise  (Rise),
    .Fall  (Fall)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the FSM sees Raw two edges late; a level is accepted after D+1
  // consecutive samples that disagree with the current level.
  bit hist[$];
  bit m_level = 0, m_rise = 0, m_fall = 0, model_valid = 0;
  int m_run = 0;

  always @(posedge Clk) begin
    if (Reset) begin
      hist = '{1'b0, 1'b0};
      m_level = 0; m_rise = 0; m_fall = 0; m_run = 0;
      model_valid = 1;
    end else if (model_valid) begin
      bit seen;
      hist.push_front(Raw);
      seen = hist[2];
      void'(hist.pop_back());
      m_rise = 0;
      m_fall = 0;
      if (seen != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = seen;
          m_rise  = seen;
          m_fall  = !seen;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  int    rise_cnt = 0;
  int    fall_cnt = 0;
  string pulse_log = "";

  always @(negedge Clk) begin
    if (model_valid) begin
      check("level_vs_model", Level, m_level);
      check("rise_vs_model", Rise, m_rise);
      check("fall_vs_model", Fall, m_fall);
      check("rise_fall_exclusive", Rise & Fall, 0);
      if (Rise) begin rise_cnt++; pulse_log = {pulse_log, "R"}; end
      if (Fall) begin fall_cnt++; pulse_log = {pulse_log, "F"}; end
    end
  end

  task automatic step(input logic r, input logic rst);
    Raw = r;
    Reset = rst;
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_counts();
    rise_cnt = 0;
    fall_cnt = 0;
    pulse_log = "";
  endtask

  task automatic reset_low();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    clear_counts();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with key held
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check("rst_level", Level, 0);
      check("rst_rise", Rise, 0);
      check("rst_fall", Fall, 0);
    end
    clear_counts();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (i == 6) check("rsthold_level_e6", Level, 0);
      if (i == 7) begin
        check("rsthold_level_e7", Level, 1);
        check("rsthold_rise_e7", Rise, 1);
      end
      if (i == 8) check("rsthold_rise_e8", Rise, 0);
    end
    check("rsthold_rise_count", rise_cnt, 1);

    // Clean press and release
    reset_low();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0);
      if (i == 6) check("press_level_e6", Level, 0);
      if (i == 7) begin
        check("press_level_e7", Level, 1);
        check("press_rise_e7", Rise, 1);
      end
      if (i == 8) check("press_rise_e8", Rise, 0);
    end
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0);
      if (i == 6) check("release_level_e6", Level, 1);
      if (i == 7) begin
        check("release_level_e7", Level, 0);
        check("release_fall_e7", Fall, 1);
      end
      if (i == 8) check("release_fall_e8", Fall, 0);
    end
    check("clean_rise_count", rise_cnt, 1);
    check("clean_fall_count", fall_cnt, 1);

    // Bounce
    reset_low();
    begin
      logic [5:0] pat;
      pat = 6'b110010;
      for (int i = 5; i >= 0; i--) step(pat[i], 1'b0);
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0);
      if (i == 6) begin
        check("bounce_level_e6", Level, 0);
        check("bounce_rise_none", rise_cnt, 0);
      end
      if (i == 7) check("bounce_rise_e7", Rise, 1);
    end
    check("bounce_rise_count", rise_cnt, 1);

    // Single-cycle glitch while low
    reset_low();
    step(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      check("glitch_low_level", Level, 0);
    end
    check("glitch_low_pulses", rise_cnt + fall_cnt, 0);

    // Single-cycle glitch while high
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    clear_counts();
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      check("glitch_high_level", Level, 1);
    end
    check("glitch_high_pulses", rise_cnt + fall_cnt, 0);

    // Reset mid-count
    reset_low();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("midcnt_cnt_before", 32'(dut.cnt), 2);
    step(1'b1, 1'b1);
    check("midcnt_level", Level, 0);
    check("midcnt_rise", Rise, 0);
    check("midcnt_cnt", 32'(dut.cnt), 0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b0);
      if (i == 6) check("midcnt_no_rise_e6", rise_cnt, 0);
      if (i == 7) check("midcnt_rise_e7", Rise, 1);
    end

    // Back-to-back toggles
    reset_low();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    check("b2b_sequence", (pulse_log == "RFR") ? 1 : 0, 1);
    check("b2b_rise_count", rise_cnt, 2);
    check("b2b_fall_count", fall_cnt, 1);

    // Random runs with occasional resets, checked cycle by cycle against the model
    reset_low();
    for (int seg = 0; seg < 150; seg++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++)
        step(v, ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end
    step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
